// File: rtl/mac_ofifo_if.sv
// Bus between the MAC array / downstream stage and the output FIFO.
//   in       : per-column psums from the array (column c in bits [psum_bw*(c+1)-1 : psum_bw*c])
//   wr       : per-column write strobes
//   rd       : read request from the accumulator/SFU
//   out      : registered aligned row
//   o_valid  : every column holds at least one entry
//   o_full   : some column holds depth entries
//   o_ready  : ~o_full
//   overflow : sticky dropped-write flag
interface mac_ofifo_if #(
    parameter int unsigned col     = 4,
    parameter int unsigned psum_bw = 16
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   overflow;

    // Upstream/downstream side: drives data, strobes and read request.
    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, overflow
    );

    // FIFO side.
    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, overflow
    );
endinterface

// File: rtl/mac_ofifo.sv
// Output-collection buffer below the MAC array. One FIFO per column absorbs
// the skewed psum arrival; a full aligned row is released on a read.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : mac_ofifo_if slave (in/wr/rd in, out/o_valid/o_full/o_ready/overflow out)
module mac_ofifo #(
    parameter int unsigned col     = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 64
) (
    input  logic         clk,
    input  logic         reset,
    mac_ofifo_if.slave   bus
);
    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;
    localparam int unsigned rw = psum_bw * col;

    logic [col-1:0] full_col;
    logic [col-1:0] nonempty_col;
    logic [col-1:0] wr_ok;
    logic [rw-1:0]  head_row;
    logic [rw-1:0]  out_q;
    logic           overflow_q;
    logic           valid_c;
    logic           full_c;
    logic           pop_c;
    logic           drop_c;

    // Status decodes depend only on the registered counts.
    assign valid_c = &nonempty_col;
    assign full_c  = |full_col;
    assign pop_c   = bus.rd & valid_c;

    // A full column still accepts a write when the row pop frees a slot this cycle.
    assign wr_ok  = bus.wr & (~full_col | {col{pop_c}});
    assign drop_c = (|(bus.wr & full_col)) & ~pop_c;

    genvar c;
    generate
        for (c = 0; c < col; c++) begin : g_col
            logic [psum_bw-1:0] mem [depth];
            logic [aw-1:0]      wr_ptr;
            logic [aw-1:0]      rd_ptr;
            logic [cw-1:0]      count;

            assign full_col[c]     = (count == cw'(depth));
            assign nonempty_col[c] = (count != '0);
            assign head_row[c*psum_bw +: psum_bw] = mem[rd_ptr];

            // Storage is not reset; stale contents are unreachable once pointers clear.
            always_ff @(posedge clk) begin
                if (reset && wr_ok[c]) begin
                    mem[wr_ptr] <= bus.in[c*psum_bw +: psum_bw];
                end
            end

            // Pointers and occupancy.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (wr_ok[c]) begin
                        wr_ptr <= wr_ptr + aw'(1);
                    end
                    if (pop_c) begin
                        rd_ptr <= rd_ptr + aw'(1);
                    end
                    case ({wr_ok[c], pop_c})
                        2'b10:   count <= count + cw'(1);
                        2'b01:   count <= count - cw'(1);
                        default: count <= count;
                    endcase
                end
            end
        end
    endgenerate

    // Registered row output and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop_c) begin
                out_q <= head_row;
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.overflow = overflow_q;
    assign bus.o_valid  = valid_c;
    assign bus.o_full   = full_c;
    assign bus.o_ready  = ~full_c;
endmodule

// File: tb/tb_mac_ofifo.sv
// Self-checking bench for mac_ofifo (col=4, psum_bw=16, depth=4).
module tb_mac_ofifo;
    localparam int unsigned COL   = 4;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = COL * PW;
    localparam int unsigned NVEC  = 17;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    mac_ofifo_if #(.col(COL), .psum_bw(PW)) bus ();

    mac_ofifo #(.col(COL), .psum_bw(PW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [3:0]   wr;
        logic [W-1:0] din;
        logic         rd;
        logic [W-1:0] q;
        logic         v;
        logic         f;
        logic         ov;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mkvec(input logic rst_n, input logic [3:0] wr, input logic [W-1:0] din,
                                   input logic rd, input logic [W-1:0] q, input logic v,
                                   input logic f, input logic ov);
        vec_t t;
        t.rst_n = rst_n; t.wr = wr; t.din = din; t.rd = rd;
        t.q = q; t.v = v; t.f = f; t.ov = ov;
        return t;
    endfunction

    // Distinct row pattern: column c of row r holds 0xA000 + 16*r + c.
    function automatic logic [W-1:0] rowv(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) begin
            v[c*PW +: PW] = 16'(32'hA000 + r * 16 + c);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] w, input logic [W-1:0] d, input logic r);
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'h0, '0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;

        // Reset, idle reads, then skewed fill: column c gets 16*c + k at cycle k + c.
        tbl[0]  = mkvec(1'b0, 4'b0000, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkvec(1'b0, 4'b0000, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkvec(1'b1, 4'b0000, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mkvec(1'b1, 4'b0000, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mkvec(1'b1, 4'b0001, 64'h0000_0000_0000_0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mkvec(1'b1, 4'b0011, 64'h0000_0000_0010_0001, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mkvec(1'b1, 4'b0111, 64'h0000_0020_0011_0002, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mkvec(1'b1, 4'b1111, 64'h0030_0021_0012_0003, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mkvec(1'b1, 4'b1110, 64'h0031_0022_0013_0000, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mkvec(1'b1, 4'b1100, 64'h0032_0023_0000_0000, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tbl[10] = mkvec(1'b1, 4'b1000, 64'h0033_0000_0000_0000, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tbl[11] = mkvec(1'b1, 4'b0000, '0, 1'b1, 64'h0030_0020_0010_0000, 1'b1, 1'b0, 1'b0);
        tbl[12] = mkvec(1'b1, 4'b0000, '0, 1'b1, 64'h0031_0021_0011_0001, 1'b1, 1'b0, 1'b0);
        tbl[13] = mkvec(1'b1, 4'b0000, '0, 1'b1, 64'h0032_0022_0012_0002, 1'b1, 1'b0, 1'b0);
        tbl[14] = mkvec(1'b1, 4'b0000, '0, 1'b1, 64'h0033_0023_0013_0003, 1'b0, 1'b0, 1'b0);
        tbl[15] = mkvec(1'b1, 4'b0000, '0, 1'b1, 64'h0033_0023_0013_0003, 1'b0, 1'b0, 1'b0);
        tbl[16] = mkvec(1'b1, 4'b0000, '0, 1'b0, 64'h0033_0023_0013_0003, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < int'(NVEC); i++) begin
            reset  = tbl[i].rst_n;
            drive(tbl[i].wr, tbl[i].din, tbl[i].rd);
            check($sformatf("vec%0d out", i),      bus.out,               tbl[i].q);
            check($sformatf("vec%0d o_valid", i),  W'(bus.o_valid),       W'(tbl[i].v));
            check($sformatf("vec%0d o_full", i),   W'(bus.o_full),        W'(tbl[i].f));
            check($sformatf("vec%0d o_ready", i),  W'(bus.o_ready),       W'(!tbl[i].f));
            check($sformatf("vec%0d overflow", i), W'(bus.overflow),      W'(tbl[i].ov));
        end

        // Full, then a dropped write to column 2 only.
        do_reset();
        for (int r = 0; r < 4; r++) drive(4'hF, rowv(r), 1'b0);
        check("fill o_full",   W'(bus.o_full),   W'(1));
        check("fill o_ready",  W'(bus.o_ready),  W'(0));
        check("fill overflow", W'(bus.overflow), W'(0));
        drive(4'b0100, {4{16'hDEAD}}, 1'b0);
        check("drop overflow", W'(bus.overflow), W'(1));
        check("drop o_full",   W'(bus.o_full),   W'(1));
        for (int r = 0; r < 4; r++) begin
            drive(4'h0, '0, 1'b1);
            check($sformatf("drop pop%0d", r), bus.out, rowv(r));
        end
        check("drop drained o_valid", W'(bus.o_valid),  W'(0));
        check("drop sticky overflow", W'(bus.overflow), W'(1));

        // Full with simultaneous write and pop.
        do_reset();
        check("reset clears overflow", W'(bus.overflow), W'(0));
        for (int r = 0; r < 4; r++) drive(4'hF, rowv(r), 1'b0);
        drive(4'hF, rowv(4), 1'b1);
        check("wrpop out",      bus.out,          rowv(0));
        check("wrpop overflow", W'(bus.overflow), W'(0));
        check("wrpop o_full",   W'(bus.o_full),   W'(1));
        for (int r = 1; r < 5; r++) begin
            drive(4'h0, '0, 1'b1);
            check($sformatf("wrpop pop%0d", r), bus.out, rowv(r));
        end
        check("wrpop drained o_valid", W'(bus.o_valid), W'(0));

        // Pointer wrap: 10 write/pop pairs.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(4'hF, rowv(10 + i), 1'b0);
            drive(4'h0, '0, 1'b1);
            check($sformatf("wrap pop%0d", i), bus.out, rowv(10 + i));
        end
        check("wrap o_valid",  W'(bus.o_valid),  W'(0));
        check("wrap overflow", W'(bus.overflow), W'(0));

        // Reset in the middle of a partial row.
        do_reset();
        drive(4'b0011, {4{16'h0077}}, 1'b0);
        reset = 1'b0;
        drive(4'h0, '0, 1'b0);
        reset = 1'b1;
        check("midrst o_valid", W'(bus.o_valid), W'(0));
        drive(4'hF, {4{16'h0055}}, 1'b0);
        check("midrst row valid", W'(bus.o_valid), W'(1));
        drive(4'h0, '0, 1'b1);
        check("midrst pop", bus.out, {4{16'h0055}});
        check("midrst no stale", W'(bus.o_valid), W'(0));
        drive(4'h0, '0, 1'b1);
        check("midrst hold", bus.out, {4{16'h0055}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
